rca_accumulator: RTL



---
 rtl/rca_accumulator.sv | 131 +++++++++++++
 1 files changed

// File: rtl/rca_accumulator.sv
// Multi-operand summing stage: ripple-carry pair adder feeding a COUNT-deep burst accumulator.
// Optional macro RCA_ACC_SATURATE_EN clamps the accumulator on overflow instead of wrapping.
module rca_accumulator #(
  parameter int SIZE      = 4,
  parameter int ACC_WIDTH = 8,
  parameter int COUNT     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [SIZE-1:0]      a,
  input  logic [SIZE-1:0]      b,
  input  logic                 cin,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [ACC_WIDTH-1:0] acc_out,
  output logic                 ovf
);

  localparam int CNT_W = (COUNT > 1) ? $clog2(COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(COUNT - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic                 ovf_q, ovf_d;

  // Full-adder ripple chain; carry[SIZE] is the pair's carry-out.
  logic [SIZE:0]   carry;
  logic [SIZE-1:0] sum_bits;

  assign carry[0] = cin;

  for (genvar i = 0; i < SIZE; i++) begin : g_fa
    assign sum_bits[i]  = a[i] ^ b[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
  end

  logic [ACC_WIDTH-1:0] psum_ext;
  logic [ACC_WIDTH:0]   acc_sum;
  logic                 add_ovf;
  logic [ACC_WIDTH-1:0] acc_add;
  logic                 accept;

  assign psum_ext = ACC_WIDTH'({carry[SIZE], sum_bits});
  assign acc_sum  = {1'b0, acc_q} + {1'b0, psum_ext};
  assign add_ovf  = acc_sum[ACC_WIDTH];

`ifdef RCA_ACC_SATURATE_EN
  // Once clamped, any further non-zero add overflows again, so the clamp holds for the burst.
  assign acc_add = add_ovf ? '1 : acc_sum[ACC_WIDTH-1:0];
`else
  assign acc_add = acc_sum[ACC_WIDTH-1:0];
`endif

  assign in_ready  = (state_q != ST_DONE);
  assign out_valid = (state_q == ST_DONE);
  assign accept    = in_valid && in_ready;
  assign acc_out   = acc_q;
  assign ovf       = ovf_q;

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          acc_d = psum_ext;
          ovf_d = 1'b0;
          if (COUNT == 1) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            state_d = ST_ACCUM;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      ST_ACCUM: begin
        if (accept) begin
          acc_d = acc_add;
          ovf_d = ovf_q | add_ovf;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over both accept and result hand-off.
    if (clr) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      acc_d   = '0;
      ovf_d   = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
